depth_compositor: RTL and testbench

// Per-pixel compositor between the camera/player pixel path and the HDMI/TMDS output stage.
// It composes N_WALLS wall layers and the player layer by depth: smaller depth is nearer.

---
 rtl/gfx_pkg.sv | 22 ++
 rtl/depth_arbiter.sv | 40 ++++
 rtl/depth_compositor.sv | 209 ++++++++++++++++++++
 tb/tb_depth_compositor.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// gfx_pkg: shared graphics constants, layer encodings and pixel type.
package gfx_pkg;

  localparam int unsigned DEPTH_W_DEF = 8;
  localparam logic [DEPTH_W_DEF-1:0] DEPTH_FAR = '1;

  typedef enum int unsigned {
    LAYER_BG     = 0,
    LAYER_PLAYER = 1,
    LAYER_WALL0  = 2
  } layer_e;

  typedef logic [15:0] rgb565_t;

  // Width needed to count every pixel of an h x v frame.
  function automatic int unsigned coll_cnt_w(input int unsigned h, input int unsigned v);
    return $clog2(h * v + 1);
  endfunction

  localparam int unsigned COLL_CNT_W = coll_cnt_w(1280, 720);

endpackage

// File: rtl/depth_arbiter.sv
// depth_arbiter: combinational nearest-layer select over N_WALLS walls plus the
// player. Equal depths resolve to a wall over the player, lower wall index first.
module depth_arbiter
  import gfx_pkg::*;
#(
  parameter int unsigned N_WALLS = 4,
  parameter int unsigned DEPTH_W = 8,
  localparam int unsigned SEL_W  = $clog2(N_WALLS + 2)
) (
  input  logic [N_WALLS-1:0]         wall_hit_in,
  input  logic [N_WALLS*DEPTH_W-1:0] wall_depth_in,
  input  logic                       player_hit_in,
  input  logic [DEPTH_W-1:0]         player_depth_in,
  output logic [SEL_W-1:0]           sel_out,
  output logic                       valid_out
);

  logic [DEPTH_W-1:0] best;

  // Strict less-than keeps the earlier candidate on ties, so walls are scanned
  // in index order and the player last.
  always_comb begin
    best      = '1;
    valid_out = 1'b0;
    sel_out   = SEL_W'(LAYER_BG);
    for (int unsigned i = 0; i < N_WALLS; i++) begin
      if (wall_hit_in[i] && (!valid_out || (wall_depth_in[i*DEPTH_W +: DEPTH_W] < best))) begin
        best      = wall_depth_in[i*DEPTH_W +: DEPTH_W];
        valid_out = 1'b1;
        sel_out   = SEL_W'(LAYER_WALL0 + i);
      end
    end
    if (player_hit_in && (!valid_out || (player_depth_in < best))) begin
      best      = player_depth_in;
      valid_out = 1'b1;
      sel_out   = SEL_W'(LAYER_PLAYER);
    end
  end

endmodule

// File: rtl/depth_compositor.sv
// depth_compositor: 2-cycle depth-ordered compositor of N_WALLS wall layers,
// the player and background, with frame-latched wall/player parameters.
// Optional per-frame collision counter enabled by COLLISION_COUNT_EN.
module depth_compositor
  import gfx_pkg::*;
#(
  parameter int unsigned ACTIVE_H_PIXELS = 1280,
  parameter int unsigned ACTIVE_LINES    = 720,
  parameter int unsigned N_WALLS         = 4,
  parameter int unsigned DEPTH_W         = 8,
  parameter int unsigned COLOR_W         = 16,
  localparam int unsigned SEL_W          = $clog2(N_WALLS + 2)
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [10:0]                  h_count_in,
  input  logic [9:0]                   v_count_in,
  input  logic                         new_frame_in,
  input  logic [N_WALLS*DEPTH_W-1:0]   wall_depth_in,
  input  logic [N_WALLS*COLOR_W-1:0]   wall_color_in,
  input  logic [N_WALLS-1:0]           wall_mask_in,
  input  logic                         player_mask_in,
  input  logic [DEPTH_W-1:0]           player_depth_in,
  input  logic [COLOR_W-1:0]           pixel_in,
  input  logic [COLOR_W-1:0]           bg_color_in,
  output logic [10:0]                  hcount_out,
  output logic [9:0]                   vcount_out,
  output logic [COLOR_W-1:0]           pixel_out,
  output logic                         data_valid_out,
  output logic [SEL_W-1:0]             layer_sel_out,
  output logic [COLL_CNT_W-1:0]        collision_count_out,
  output logic                         collision_valid_out
);

  localparam logic [10:0] H_LIM = 11'(ACTIVE_H_PIXELS);
  localparam logic [9:0]  V_LIM = 10'(ACTIVE_LINES);

  logic [N_WALLS*DEPTH_W-1:0] wall_depth_q, wall_depth_d;
  logic [N_WALLS*COLOR_W-1:0] wall_color_q, wall_color_d;
  logic [DEPTH_W-1:0]         player_depth_q, player_depth_d;

  logic                s1_vld_q, s1_vld_d;
  logic [10:0]         s1_h_q, s1_h_d;
  logic [9:0]          s1_v_q, s1_v_d;
  logic                s1_active_q, s1_active_d;
  logic [N_WALLS-1:0]  s1_wmask_q, s1_wmask_d;
  logic                s1_pmask_q, s1_pmask_d;
  logic [COLOR_W-1:0]  s1_pix_q, s1_pix_d;
  logic [COLOR_W-1:0]  s1_bg_q, s1_bg_d;

  logic [10:0]         hcount_q, hcount_d;
  logic [9:0]          vcount_q, vcount_d;
  logic [COLOR_W-1:0]  pixel_q, pixel_d;
  logic                dvalid_q, dvalid_d;
  logic [SEL_W-1:0]    sel_q, sel_d;

  logic [SEL_W-1:0]    arb_sel;
  logic                arb_valid;
  logic [COLOR_W-1:0]  win_color;

  depth_arbiter #(
    .N_WALLS (N_WALLS),
    .DEPTH_W (DEPTH_W)
  ) u_arb (
    .wall_hit_in     (s1_wmask_q),
    .wall_depth_in   (wall_depth_q),
    .player_hit_in   (s1_pmask_q),
    .player_depth_in (player_depth_q),
    .sel_out         (arb_sel),
    .valid_out       (arb_valid)
  );

  // Frame latch, stage-1 capture and stage-2 output selection.
  always_comb begin
    wall_depth_d   = wall_depth_q;
    wall_color_d   = wall_color_q;
    player_depth_d = player_depth_q;
    if (new_frame_in) begin
      wall_depth_d   = wall_depth_in;
      wall_color_d   = wall_color_in;
      player_depth_d = player_depth_in;
    end

    s1_vld_d    = 1'b1;
    s1_h_d      = h_count_in;
    s1_v_d      = v_count_in;
    s1_active_d = (h_count_in < H_LIM) && (v_count_in < V_LIM);
    s1_wmask_d  = wall_mask_in;
    s1_pmask_d  = player_mask_in;
    s1_pix_d    = pixel_in;
    s1_bg_d     = bg_color_in;

    win_color = '0;
    for (int unsigned i = 0; i < N_WALLS; i++) begin
      if (arb_sel == SEL_W'(LAYER_WALL0 + i)) begin
        win_color = wall_color_q[i*COLOR_W +: COLOR_W];
      end
    end

    hcount_d = s1_vld_q ? s1_h_q : '0;
    vcount_d = s1_vld_q ? s1_v_q : '0;
    dvalid_d = s1_vld_q && s1_active_q;
    pixel_d  = '0;
    sel_d    = '0;
    if (dvalid_d) begin
      sel_d = arb_sel;
      if (!arb_valid) begin
        pixel_d = s1_bg_q;
      end else if (arb_sel == SEL_W'(LAYER_PLAYER)) begin
        pixel_d = s1_pix_q;
      end else begin
        pixel_d = win_color;
      end
    end
  end

  // Shadow parameters and both pipeline stages.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wall_depth_q   <= '1;
      wall_color_q   <= '0;
      player_depth_q <= '1;
      s1_vld_q       <= 1'b0;
      s1_h_q         <= '0;
      s1_v_q         <= '0;
      s1_active_q    <= 1'b0;
      s1_wmask_q     <= '0;
      s1_pmask_q     <= 1'b0;
      s1_pix_q       <= '0;
      s1_bg_q        <= '0;
      hcount_q       <= '0;
      vcount_q       <= '0;
      pixel_q        <= '0;
      dvalid_q       <= 1'b0;
      sel_q          <= '0;
    end else begin
      wall_depth_q   <= wall_depth_d;
      wall_color_q   <= wall_color_d;
      player_depth_q <= player_depth_d;
      s1_vld_q       <= s1_vld_d;
      s1_h_q         <= s1_h_d;
      s1_v_q         <= s1_v_d;
      s1_active_q    <= s1_active_d;
      s1_wmask_q     <= s1_wmask_d;
      s1_pmask_q     <= s1_pmask_d;
      s1_pix_q       <= s1_pix_d;
      s1_bg_q        <= s1_bg_d;
      hcount_q       <= hcount_d;
      vcount_q       <= vcount_d;
      pixel_q        <= pixel_d;
      dvalid_q       <= dvalid_d;
      sel_q          <= sel_d;
    end
  end

  assign hcount_out     = hcount_q;
  assign vcount_out     = vcount_q;
  assign pixel_out      = pixel_q;
  assign data_valid_out = dvalid_q;
  assign layer_sel_out  = sel_q;

`ifdef COLLISION_COUNT_EN
  logic                  s1_collide_q, s1_collide_d;
  logic [COLL_CNT_W-1:0] cnt_q, cnt_d, cnt_sum;
  logic [COLL_CNT_W-1:0] ccount_q, ccount_d;
  logic                  cvalid_q, cvalid_d;

  // Collision detect at stage 1, saturating count at stage 2, frame-boundary report.
  always_comb begin
    s1_collide_d = 1'b0;
    for (int unsigned i = 0; i < N_WALLS; i++) begin
      if (wall_mask_in[i] && (wall_depth_q[i*DEPTH_W +: DEPTH_W] <= player_depth_q)) begin
        s1_collide_d = 1'b1;
      end
    end
    s1_collide_d = s1_collide_d && player_mask_in;

    cnt_sum = cnt_q;
    if (s1_vld_q && s1_active_q && s1_collide_q && (cnt_q != '1)) begin
      cnt_sum = cnt_q + COLL_CNT_W'(1);
    end
    cnt_d    = new_frame_in ? '0 : cnt_sum;
    ccount_d = new_frame_in ? cnt_sum : ccount_q;
    cvalid_d = new_frame_in;
  end

  // Collision counter state.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_collide_q <= 1'b0;
      cnt_q        <= '0;
      ccount_q     <= '0;
      cvalid_q     <= 1'b0;
    end else begin
      s1_collide_q <= s1_collide_d;
      cnt_q        <= cnt_d;
      ccount_q     <= ccount_d;
      cvalid_q     <= cvalid_d;
    end
  end

  assign collision_count_out = ccount_q;
  assign collision_valid_out = cvalid_q;
`else
  assign collision_count_out = '0;
  assign collision_valid_out = 1'b0;
`endif

endmodule

// File: tb/tb_depth_compositor.sv
// tb_depth_compositor: directed and randomized checks of depth_compositor
// against a frame-level reference model held in the bench.
module tb_depth_compositor;
  import gfx_pkg::*;

  localparam int unsigned NW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 16;
  localparam int unsigned SW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [10:0]      h;
  logic [9:0]       v;
  logic             nf;
  logic [NW*DW-1:0] wd;
  logic [NW*CW-1:0] wc;
  logic [NW-1:0]    wm;
  logic             pm;
  logic [DW-1:0]    pd;
  logic [CW-1:0]    pix;
  logic [CW-1:0]    bg;

  logic [10:0]      hcount_out;
  logic [9:0]       vcount_out;
  logic [CW-1:0]    pixel_out;
  logic             data_valid_out;
  logic [SW-1:0]    layer_sel_out;
  logic [19:0]      collision_count_out;
  logic             collision_valid_out;

  depth_compositor #(
    .ACTIVE_H_PIXELS (1280),
    .ACTIVE_LINES    (720),
    .N_WALLS         (NW),
    .DEPTH_W         (DW),
    .COLOR_W         (CW)
  ) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .h_count_in          (h),
    .v_count_in          (v),
    .new_frame_in        (nf),
    .wall_depth_in       (wd),
    .wall_color_in       (wc),
    .wall_mask_in        (wm),
    .player_mask_in      (pm),
    .player_depth_in     (pd),
    .pixel_in            (pix),
    .bg_color_in         (bg),
    .hcount_out          (hcount_out),
    .vcount_out          (vcount_out),
    .pixel_out           (pixel_out),
    .data_valid_out      (data_valid_out),
    .layer_sel_out       (layer_sel_out),
    .collision_count_out (collision_count_out),
    .collision_valid_out (collision_valid_out)
  );

  typedef struct {
    logic [10:0]   h;
    logic [9:0]    v;
    logic [CW-1:0] pix;
    logic          dv;
    logic [SW-1:0] sel;
    bit            coll;
  } exp_t;

  exp_t          pipe[$];
  logic [DW-1:0] m_wd[NW];
  logic [CW-1:0] m_wc[NW];
  logic [DW-1:0] m_pd;
  int unsigned   m_cnt;
  int unsigned   m_cc;
  bit            m_cv;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // What the current input pixel must become, from the layering rules.
  function automatic exp_t model();
    exp_t e;
    int   best;
    int   w;
    e.h    = h;
    e.v    = v;
    e.dv   = (int'(h) < 1280) && (int'(v) < 720);
    e.pix  = '0;
    e.sel  = '0;
    e.coll = 1'b0;
    if (e.dv) begin
      best = 256;
      for (int i = 0; i < int'(NW); i++)
        if (wm[i] && int'(m_wd[i]) < best) best = int'(m_wd[i]);
      if (pm && int'(m_pd) < best) best = int'(m_pd);
      if (best == 256) begin
        e.pix = bg;
      end else begin
        w = -1;
        for (int i = 0; i < int'(NW); i++)
          if (w < 0 && wm[i] && int'(m_wd[i]) == best) w = i;
        if (w >= 0) begin
          e.pix = m_wc[w];
          e.sel = SW'(2 + w);
        end else begin
          e.pix = pix;
          e.sel = SW'(1);
        end
      end
      for (int i = 0; i < int'(NW); i++)
        if (pm && wm[i] && m_wd[i] <= m_pd) e.coll = 1'b1;
    end
    return e;
  endfunction

  // One clock: predict, advance, compare all outputs.
  task automatic step();
    exp_t e;
    exp_t o;
    exp_t z;
    int unsigned sum;
    z = '{h: '0, v: '0, pix: '0, dv: 1'b0, sel: '0, coll: 1'b0};
    e = model();
    if (rst) begin
      for (int i = 0; i < int'(NW); i++) begin
        m_wd[i] = '1;
        m_wc[i] = '0;
      end
      m_pd  = '1;
      m_cnt = 0;
      m_cc  = 0;
      m_cv  = 1'b0;
      pipe.delete();
      @(posedge clk);
      @(negedge clk);
      o = z;
      pipe.push_back(z);
    end else begin
      if (nf) begin
        for (int i = 0; i < int'(NW); i++) begin
          m_wd[i] = wd[i*DW +: DW];
          m_wc[i] = wc[i*CW +: CW];
        end
        m_pd = pd;
      end
      pipe.push_back(e);
      @(posedge clk);
      @(negedge clk);
      o = pipe.pop_front();
`ifdef COLLISION_COUNT_EN
      sum = m_cnt + (o.coll ? 1 : 0);
      if (sum > 20'hFFFFF) sum = 20'hFFFFF;
      if (nf) begin
        m_cc  = sum;
        m_cv  = 1'b1;
        m_cnt = 0;
      end else begin
        m_cnt = sum;
        m_cv  = 1'b0;
      end
`else
      sum = 0;
`endif
    end
    chk("hcount", 32'(hcount_out), 32'(o.h));
    chk("vcount", 32'(vcount_out), 32'(o.v));
    chk("pixel", 32'(pixel_out), 32'(o.pix));
    chk("data_valid", 32'(data_valid_out), 32'(o.dv));
    chk("layer_sel", 32'(layer_sel_out), 32'(o.sel));
    chk("coll_count", 32'(collision_count_out), m_cc);
    chk("coll_valid", 32'(collision_valid_out), 32'(m_cv));
  endtask

  task automatic drive(input int hh, input int vv, input logic [NW-1:0] wmask,
                       input logic pmask, input logic [CW-1:0] p);
    h   = 11'(hh);
    v   = 10'(vv);
    wm  = wmask;
    pm  = pmask;
    pix = p;
  endtask

  task automatic idle();
    drive(1300, 730, '0, 1'b0, '0);
    step();
  endtask

  // Blanking gap, then the new_frame pulse; caller may check right after.
  task automatic frame();
    idle();
    idle();
    drive(1300, 730, '0, 1'b0, '0);
    nf = 1'b1;
    step();
    nf = 1'b0;
  endtask

  function automatic logic [DW-1:0] rdepth();
    return ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom_range(0, 7));
  endfunction

  initial begin
    rst = 1'b1;
    nf  = 1'b0;
    wd  = '0;
    wc  = '0;
    pd  = '0;
    bg  = 16'h1234;
    drive(0, 0, '0, 1'b0, '0);
    repeat (3) step();
    chk("reset_valid", 32'(data_valid_out), 32'd0);
    rst = 1'b0;

    // Lone active pixel with nothing covering it.
    drive(100, 50, '0, 1'b0, 16'hABCD);
    step();
    idle();
    chk("t1_h", 32'(hcount_out), 32'd100);
    chk("t1_v", 32'(vcount_out), 32'd50);
    chk("t1_dv", 32'(data_valid_out), 32'd1);
    chk("t1_pix", 32'(pixel_out), 32'h1234);
    chk("t1_sel", 32'(layer_sel_out), 32'd0);

    // Two walls, nearer one wins; then equal depths, lower index wins.
    wd = {8'hFF, 8'hFF, 8'd20, 8'd40};
    wc = {16'h0000, 16'h0000, 16'h07E0, 16'hF800};
    pd = 8'hFF;
    frame();
    drive(10, 10, 4'b0011, 1'b0, 16'h1111);
    step();
    idle();
    chk("t2_pix", 32'(pixel_out), 32'h07E0);
    chk("t2_sel", 32'(layer_sel_out), 32'd3);
    wd = {8'hFF, 8'hFF, 8'd20, 8'd20};
    frame();
    drive(11, 10, 4'b0011, 1'b0, 16'h1111);
    step();
    idle();
    chk("t2_tie_pix", 32'(pixel_out), 32'hF800);
    chk("t2_tie_sel", 32'(layer_sel_out), 32'd2);

    // Player against wall: tie goes to wall, farther wall loses.
    wd = {8'hFF, 8'hFF, 8'hFF, 8'd30};
    pd = 8'd30;
    frame();
    drive(12, 10, 4'b0001, 1'b1, 16'h5A5A);
    step();
    idle();
    chk("t3_tie_sel", 32'(layer_sel_out), 32'd2);
    chk("t3_tie_pix", 32'(pixel_out), 32'hF800);
    wd = {8'hFF, 8'hFF, 8'hFF, 8'd31};
    frame();
    drive(13, 10, 4'b0001, 1'b1, 16'h5A5A);
    step();
    idle();
    chk("t3_pl_sel", 32'(layer_sel_out), 32'd1);
    chk("t3_pl_pix", 32'(pixel_out), 32'h5A5A);

    // Mid-frame parameter change is ignored until the next frame pulse.
    wd = {8'hFF, 8'hFF, 8'hFF, 8'd0};
    drive(14, 10, 4'b0001, 1'b1, 16'h5A5A);
    step();
    idle();
    chk("t4_hold_sel", 32'(layer_sel_out), 32'd1);
    frame();
    drive(15, 10, 4'b0001, 1'b1, 16'h5A5A);
    step();
    idle();
    chk("t4_new_sel", 32'(layer_sel_out), 32'd2);

    // Active-region boundaries.
    drive(1280, 5, 4'b0001, 1'b1, 16'h7777);
    step();
    idle();
    chk("t5_h_dv", 32'(data_valid_out), 32'd0);
    chk("t5_h_pix", 32'(pixel_out), 32'd0);
    chk("t5_h_cnt", 32'(hcount_out), 32'd1280);
    drive(5, 720, 4'b0001, 1'b1, 16'h7777);
    step();
    idle();
    chk("t5_v_dv", 32'(data_valid_out), 32'd0);
    drive(1279, 719, '0, 1'b0, 16'h7777);
    step();
    idle();
    chk("t5_corner_dv", 32'(data_valid_out), 32'd1);

    // Reset in the middle of a line.
    drive(20, 30, '0, 1'b0, 16'h0101);
    step();
    drive(21, 30, '0, 1'b0, 16'h0202);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_rst1_dv", 32'(data_valid_out), 32'd0);
    drive(22, 30, '0, 1'b0, 16'h0303);
    step();
    chk("t5_rst2_dv", 32'(data_valid_out), 32'd0);
    chk("t5_rst2_h", 32'(hcount_out), 32'd0);
    idle();
    chk("t5_rst3_h", 32'(hcount_out), 32'd22);
    chk("t5_rst3_pix", 32'(pixel_out), 32'h1234);

`ifdef COLLISION_COUNT_EN
    // Collision counting over a frame.
    wd = {8'hFF, 8'hFF, 8'hFF, 8'd10};
    pd = 8'd20;
    frame();
    for (int i = 0; i < 1000; i++) begin
      drive(i % 1280, 100, 4'b0001, 1'b1, 16'($urandom));
      step();
    end
    frame();
    chk("t6_count", 32'(collision_count_out), 32'd1000);
    chk("t6_valid", 32'(collision_valid_out), 32'd1);
    idle();
    chk("t6_valid_pulse", 32'(collision_valid_out), 32'd0);
    for (int i = 0; i < 50; i++) begin
      drive(i, 101, 4'b0001, 1'b0, 16'($urandom));
      step();
    end
    frame();
    chk("t6_zero", 32'(collision_count_out), 32'd0);
    chk("t6_zero_valid", 32'(collision_valid_out), 32'd1);
`endif

    // Randomized frames; unlatched parameter inputs keep changing.
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < int'(NW); i++) begin
        wd[i*DW +: DW] = rdepth();
        wc[i*CW +: CW] = 16'($urandom);
      end
      pd = rdepth();
      bg = 16'($urandom);
      frame();
      for (int k = 0; k < 400; k++) begin
        drive(($urandom_range(0, 9) == 0) ? int'($urandom_range(1276, 1284)) : int'($urandom_range(0, 1279)),
              ($urandom_range(0, 9) == 0) ? int'($urandom_range(716, 724)) : int'($urandom_range(0, 719)),
              NW'($urandom), 1'($urandom), 16'($urandom));
        wd = $urandom;
        wc = {$urandom, $urandom};
        pd = 8'($urandom);
        step();
      end
    end
    idle();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
